// File: rtl/timer_seq_ctrl.sv
// Load/prescale/expiry sequencer for the timer's cascaded 4-bit counter stages.
// Define TIMER_EXPCNT_EN to build the saturating expiry counter on exp_cnt.
module timer_seq_ctrl #(
    parameter int W     = 4,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             clr_b,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [W-1:0]     preset,
    input  logic [PRE_W-1:0] prescale,
    input  logic             cnt_tc,
    output logic             cnt_load,
    output logic             cnt_en,
    output logic [W-1:0]     cnt_din,
    output logic             irq,
    output logic             busy,
    output logic [7:0]       exp_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     din_q, din_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] pc_q, pc_d;
    logic             per_q, per_d;
    logic             irq_q, irq_d;
    logic             load_q, load_d;
    logic             busy_q, busy_d;
    logic             tick;
    logic             accept;
    logic             expire;

    assign tick   = (state_q == S_RUN) && (pc_q == pre_q);
    assign cnt_en = tick & ~stop;
    assign expire = cnt_en & cnt_tc;
    assign accept = (state_q == S_IDLE) & start & ~stop;

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        pre_d   = pre_q;
        pc_d    = pc_q;
        per_d   = per_q;
        irq_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    din_d   = preset;
                    pre_d   = prescale;
                    per_d   = periodic;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pc_d    = '0;
                state_d = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                pc_d = tick ? '0 : pc_q + PRE_W'(1);
                if (stop) begin
                    state_d = S_IDLE;
                end else if (expire) begin
                    irq_d   = 1'b1;
                    state_d = per_q ? S_LOAD : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        load_d = (state_d == S_LOAD);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge clr_b) begin
        if (!clr_b) begin
            state_q <= S_IDLE;
            din_q   <= '0;
            pre_q   <= '0;
            pc_q    <= '0;
            per_q   <= 1'b0;
            irq_q   <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            pre_q   <= pre_d;
            pc_q    <= pc_d;
            per_q   <= per_d;
            irq_q   <= irq_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
        end
    end

    assign cnt_load = load_q;
    assign cnt_din  = din_q;
    assign irq      = irq_q;
    assign busy     = busy_q;

`ifdef TIMER_EXPCNT_EN
    logic [7:0] exp_q, exp_d;

    // cleared on a new start, otherwise counts expiries and sticks at 255
    always_comb begin
        exp_d = exp_q;
        if (accept) begin
            exp_d = '0;
        end else if (expire && (exp_q != 8'hFF)) begin
            exp_d = exp_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge clr_b) begin
        if (!clr_b) begin
            exp_q <= '0;
        end else begin
            exp_q <= exp_d;
        end
    end

    assign exp_cnt = exp_q;
`else
    assign exp_cnt = '0;
`endif

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed bench for timer_seq_ctrl with a behavioural 4-bit counter stage.
module tb_timer_seq_ctrl;

    logic       clk = 1'b0;
    logic       clr_b;
    logic       start, stop, periodic;
    logic [3:0] preset;
    logic [7:0] prescale;
    logic       cnt_tc;
    logic       cnt_load, cnt_en, irq, busy;
    logic [3:0] cnt_din;
    logic [7:0] exp_cnt;
    logic [3:0] cnt_m;
    logic       tc_force;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef TIMER_EXPCNT_EN
    localparam bit EXPC = 1'b1;
`else
    localparam bit EXPC = 1'b0;
`endif

    timer_seq_ctrl #(.W(4), .PRE_W(8)) dut (
        .clk      (clk),
        .clr_b    (clr_b),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .preset   (preset),
        .prescale (prescale),
        .cnt_tc   (cnt_tc),
        .cnt_load (cnt_load),
        .cnt_en   (cnt_en),
        .cnt_din  (cnt_din),
        .irq      (irq),
        .busy     (busy),
        .exp_cnt  (exp_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge clr_b) begin
        if (!clr_b) cnt_m <= '0;
        else if (cnt_load) cnt_m <= cnt_din;
        else if (cnt_en) cnt_m <= cnt_m + 4'd1;
    end

    assign cnt_tc = ((cnt_m == 4'hF) & cnt_en) | tc_force;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        start    = 1'b0;
        stop     = 1'b0;
        tc_force = 1'b0;
        #1;
    endtask

    task automatic wait_irq(input int bound, output int ens, output bit ok);
        ens = 0;
        ok  = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            tick();
            if (cnt_en) ens++;
            if (irq) ok = 1'b1;
        end
    endtask

    int  ens;
    bit  ok;
    logic [2:0] pat;

    initial begin
        clr_b = 1'b0; start = 1'b0; stop = 1'b0; periodic = 1'b0;
        preset = '0; prescale = '0; tc_force = 1'b0;
        #12;
        chk("rst_out", {busy, cnt_load, cnt_en, irq, cnt_din, exp_cnt}, 0);
        #10 clr_b = 1'b1;
        tick();

        // one-shot, preset 12, prescale 0
        periodic = 1'b0; preset = 4'd12; prescale = 8'd0; start = 1'b1;
        tick();
        chk("t1_load", {cnt_load, busy, cnt_en}, 3'b110);
        chk("t1_din", cnt_din, 12);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) begin
                start = 1'b1; preset = 4'd3;
            end
            #1;
            chk("t1_en", {cnt_en, irq, cnt_load}, 3'b100);
        end
        tick();
        chk("t1_irq", {irq, busy, cnt_load, cnt_en}, 4'b1000);
        chk("t1_din_hold", cnt_din, 12);
        tick();
        chk("t1_irq_off", irq, 0);

        // periodic, preset 14, prescale 2: period 7
        periodic = 1'b1; preset = 4'd14; prescale = 8'd2; start = 1'b1;
        tick();
        for (int i = 0; i < 140; i++) begin
            if (i > 0) tick();
            pat = {(i % 7 == 0), (i % 7 == 3) || (i % 7 == 6),
                   (i % 7 == 0) && (i > 0)};
            chk("t2_seq", {cnt_load, cnt_en, irq}, pat);
            if (i == 21) chk("t2_exp3", exp_cnt, EXPC ? 3 : 0);
        end
        tick();
        stop = 1'b1;
        #1;
        chk("t2_irq_last", {irq, cnt_en}, 2'b10);
        chk("t2_exp20", exp_cnt, EXPC ? 20 : 0);
        tick();
        chk("t2_stopped", {busy, cnt_load}, 0);

        // preset 0, one-shot: 16 ticks; tc in LOAD ignored
        periodic = 1'b0; preset = 4'd0; prescale = 8'd0; start = 1'b1;
        tick();
        tc_force = 1'b1;
        wait_irq(40, ens, ok);
        chk("t3_irq_seen", ok, 1);
        chk("t3_ticks", ens, 16);
        chk("t3_idle", busy, 0);

        // stop on tick with cnt_tc high
        periodic = 1'b0; preset = 4'd15; prescale = 8'd1; start = 1'b1;
        tick();
        tick();
        chk("t4_pc0", cnt_en, 0);
        tick();
        chk("t4_tick", cnt_en, 1);
        stop = 1'b1; tc_force = 1'b1;
        #1;
        chk("t4_stop_en", cnt_en, 0);
        tick();
        chk("t4_no_irq", {busy, irq}, 0);
        tick();
        chk("t4_no_irq2", irq, 0);
        preset = 4'd7; start = 1'b1; stop = 1'b1;
        tick();
        chk("t4_ss_idle", {busy, cnt_load}, 0);
        chk("t4_ss_din", cnt_din, 15);

        // asynchronous clear mid-RUN
        periodic = 1'b1; preset = 4'd0; prescale = 8'd3; start = 1'b1;
        tick();
        tick();
        tick();
        chk("t5_running", busy, 1);
        #1 clr_b = 1'b0;
        #1;
        chk("t5_clr", {busy, cnt_load, cnt_en, irq, cnt_din, exp_cnt}, 0);
        #2 clr_b = 1'b1;
        periodic = 1'b0; preset = 4'd12; prescale = 8'd0; start = 1'b1;
        tick();
        chk("t5_load", {cnt_load, cnt_din}, {1'b1, 4'd12});
        wait_irq(20, ens, ok);
        chk("t5_irq_seen", ok, 1);
        chk("t5_ticks", ens, 4);

        // saturation: period 2, >300 expiries
        periodic = 1'b1; preset = 4'd15; prescale = 8'd0; start = 1'b1;
        tick();
        repeat (610) tick();
        chk("t6_sat", exp_cnt, EXPC ? 255 : 0);
        stop = 1'b1;
        tick();
        chk("t6_hold", {busy, exp_cnt}, {1'b0, (EXPC ? 8'd255 : 8'd0)});
        periodic = 1'b0; start = 1'b1;
        tick();
        chk("t6_clr", {busy, exp_cnt}, {1'b1, 8'd0});

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
